// File: rtl/vga_capture.sv
// VGA receive-side capture: recovers h/v position from HS/VS, tracks 640x480 lock, emits active pixels.
// Define VGA_CHECKSUM_EN to build the per-frame active-pixel checksum on frame_sum.
//
// state     | meaning
// UNLOCKED  | waiting for the first VS fall
// SEEK      | counting consecutive clean frames toward lock
// LOCKED    | timing matches; pixels are emitted
module vga_capture #(
    parameter int H_SYNC      = 128,
    parameter int H_BACK      = 16,
    parameter int H_ACTIVE    = 640,
    parameter int H_TOTAL     = 800,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int V_ACTIVE    = 480,
    parameter int V_TOTAL     = 525,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk25M,
    input  logic        reset,
    input  logic        HS,
    input  logic        VS,
    input  logic [2:0]  red_in,
    input  logic [2:0]  green_in,
    input  logic [1:0]  blue_in,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [2:0]  pix_red,
    output logic [2:0]  pix_green,
    output logic [1:0]  pix_blue,
    output logic        locked,
    output logic        frame_start,
    output logic [7:0]  err_count,
    output logic [15:0] frame_sum
);

    localparam logic [1:0] ST_UNLOCKED = 2'd0;
    localparam logic [1:0] ST_SEEK     = 2'd1;
    localparam logic [1:0] ST_LOCKED   = 2'd2;

    localparam int GW = $clog2(LOCK_FRAMES + 1);
    localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_FRAMES - 1);

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_LO   = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] H_HI   = 10'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [9:0] V_LO   = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] V_HI   = 10'(V_SYNC + V_BACK + V_ACTIVE);
    localparam logic [9:0] CNT_MAX = 10'h3FF;

    logic          hs_q, hs_qq, vs_q, vs_qq;
    logic [7:0]    rgb_q;
    logic          hs_fall, vs_fall;
    logic [9:0]    hcnt, vcnt;
    logic          seen_hs, seen_vs;
    logic          line_err, frame_err, frame_bad, frame_good;
    logic [1:0]    state;
    logic [GW-1:0] good_cnt;
    logic          in_active;

    assign hs_fall    = !hs_q && hs_qq;
    assign vs_fall    = !vs_q && vs_qq;
    assign line_err   = hs_fall && seen_hs && (hcnt != H_LAST);
    assign frame_err  = vs_fall && (vcnt != V_LAST);
    assign frame_good = !frame_err && !line_err && !frame_bad;
    assign locked     = (state == ST_LOCKED);
    assign in_active  = (hcnt >= H_LO) && (hcnt < H_HI) && (vcnt >= V_LO) && (vcnt < V_HI);

    // Sync history resets high so the first sample after reset cannot look like an edge.
    always_ff @(posedge clk25M) begin
        if (reset) begin
            hs_q  <= 1'b1;
            hs_qq <= 1'b1;
            vs_q  <= 1'b1;
            vs_qq <= 1'b1;
            rgb_q <= 8'h00;
        end else begin
            hs_q  <= HS;
            hs_qq <= hs_q;
            vs_q  <= VS;
            vs_qq <= vs_q;
            rgb_q <= {red_in, green_in, blue_in};
        end
    end

    always_ff @(posedge clk25M) begin
        if (reset) begin
            hcnt    <= 10'd0;
            vcnt    <= 10'd0;
            seen_hs <= 1'b0;
            seen_vs <= 1'b0;
        end else begin
            if (hs_fall) begin
                hcnt    <= 10'd0;
                seen_hs <= 1'b1;
            end else if (hcnt != CNT_MAX) begin
                hcnt <= hcnt + 10'd1;
            end
            if (vs_fall) begin
                vcnt    <= 10'd0;
                seen_vs <= 1'b1;
            end else if (hs_fall && (vcnt != CNT_MAX)) begin
                vcnt <= vcnt + 10'd1;
            end
        end
    end

    always_ff @(posedge clk25M) begin
        if (reset) begin
            state       <= ST_UNLOCKED;
            good_cnt    <= '0;
            frame_bad   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= vs_fall && locked;
            if (vs_fall)
                frame_bad <= 1'b0;
            else if (line_err)
                frame_bad <= 1'b1;
            case (state)
                ST_UNLOCKED: begin
                    if (vs_fall) begin
                        state    <= ST_SEEK;
                        good_cnt <= '0;
                    end
                end
                ST_SEEK: begin
                    if (vs_fall) begin
                        if (frame_good) begin
                            good_cnt <= good_cnt + GW'(1);
                            if (good_cnt == GOOD_LAST)
                                state <= ST_LOCKED;
                        end else begin
                            good_cnt <= '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (line_err || frame_err) begin
                        state    <= ST_UNLOCKED;
                        good_cnt <= '0;
                    end
                end
                default: begin
                    state    <= ST_UNLOCKED;
                    good_cnt <= '0;
                end
            endcase
        end
    end

    // Errors in the partial frame before the first VS fall are expected and not counted.
    always_ff @(posedge clk25M) begin
        if (reset)
            err_count <= 8'd0;
        else if (seen_vs && (line_err || frame_err) && (err_count != 8'hFF))
            err_count <= err_count + 8'd1;
    end

    always_ff @(posedge clk25M) begin
        if (reset) begin
            pix_valid <= 1'b0;
            pix_x     <= 10'd0;
            pix_y     <= 10'd0;
            pix_red   <= 3'd0;
            pix_green <= 3'd0;
            pix_blue  <= 2'd0;
        end else begin
            pix_valid <= locked && in_active;
            if (locked && in_active) begin
                pix_x                          <= hcnt - H_LO;
                pix_y                          <= vcnt - V_LO;
                {pix_red, pix_green, pix_blue} <= rgb_q;
            end else begin
                {pix_red, pix_green, pix_blue} <= 8'h00;
            end
        end
    end

`ifdef VGA_CHECKSUM_EN
    logic [15:0] acc;

    always_ff @(posedge clk25M) begin
        if (reset) begin
            acc       <= 16'h0000;
            frame_sum <= 16'h0000;
        end else if (vs_fall) begin
            acc <= 16'h0000;
            if (locked)
                frame_sum <= acc;
        end else if (pix_valid) begin
            acc <= acc + {8'h00, pix_red, pix_green, pix_blue};
        end
    end
`else
    assign frame_sum = 16'h0000;
`endif

endmodule

// File: doc/vga_capture.md
Name: vga_capture

Overview:
- Receive-side counterpart to the VGA pixel generator: consumes HS, VS and 8-bit RGB (3/3/2) at pixel rate.
- Recovers horizontal/vertical position, checks timing against the 640x480 format and reports lock.
- Emits per-pixel valid/x/y/colour for a downstream checker or frame store.
- Sits in the loopback test harness, fed directly by the graphics block's outputs.

Parameters:
- H_SYNC, 128, HS low width in pixel clocks
- H_BACK, 16, horizontal back porch
- H_ACTIVE, 640, visible pixels per line
- H_TOTAL, 800, pixel clocks per line
- V_SYNC, 2, VS low width in lines
- V_BACK, 33, vertical back porch
- V_ACTIVE, 480, visible lines
- V_TOTAL, 525, lines per frame
- LOCK_FRAMES, 2, consecutive good frames required for lock

Ports:
- clk25M  in  1  pixel clock
- reset  in  1  synchronous, active-high
- HS  in  1  horizontal sync, active low
- VS  in  1  vertical sync, active low
- red_in  in  3  pixel red
- green_in  in  3  pixel green
- blue_in  in  2  pixel blue
- pix_valid  out  1  capture outputs hold an active pixel
- pix_x  out  10  active x, 0..639
- pix_y  out  10  active y, 0..479
- pix_red  out  3  captured red
- pix_green  out  3  captured green
- pix_blue  out  2  captured blue
- locked  out  1  timing lock
- frame_start  out  1  one-cycle pulse on VS fall while locked
- err_count  out  8  saturating timing-error count
- frame_sum  out  16  active-pixel checksum of the last frame (see optional feature)

Behaviour:
- Reset: clk25M and reset are the only clock and reset; reset is synchronous and active-high. All registers clear. pix_* = 0, locked = 0, frame_start = 0, err_count = 0, frame_sum = 0, FSM = UNLOCKED. The sync history registers reset to 1 so no false edge follows reset.
- Stage 1: HS/VS/RGB register into *_q. HS_q/VS_q then delay again into *_qq.
- Edges: hs_fall = !HS_q & HS_qq; vs_fall = !VS_q & VS_qq.
- hcnt (10b):
  - 0 on hs_fall, else hcnt+1, saturating at 1023.
  - On hs_fall with hcnt != H_TOTAL-1: line_err. Exception: the first hs_fall after reset is never an error.
- vcnt (10b):
  - 0 on vs_fall; vs_fall wins when it coincides with hs_fall.
  - Otherwise +1 on hs_fall, saturating at 1023.
  - On vs_fall with vcnt != V_TOTAL-1: frame_err.
- FSM:
  - UNLOCKED -> SEEK on first vs_fall; good counter = 0.
  - In SEEK, at each vs_fall: the frame is good if there is no frame_err and no line_err since the previous vs_fall. A good frame increments the counter; a bad frame clears it. The counter reaching LOCK_FRAMES moves the FSM to LOCKED on that same vs_fall.
  - LOCKED -> UNLOCKED on any line_err or frame_err, effective next cycle; counter cleared.
- err_count: +1 per cycle with line_err or frame_err, in any state except the first frame after reset. Saturates at 255. A cycle with both errors counts once.
- Stage 2, registered from stage-1 counts and RGB_q:
  - pix_valid = locked & hcnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_ACTIVE) & vcnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_ACTIVE).
  - pix_x = hcnt-144 and pix_y = vcnt-35 when valid, else hold.
  - Colour = RGB_q when valid, else 0.
  - Latency HS/RGB pin -> pix_*: 2 clocks.
- frame_start: asserts the cycle after vs_fall when the FSM is LOCKED at that vs_fall.
- Reset mid-frame: immediate UNLOCKED and all outputs 0. Relock requires LOCK_FRAMES+1 VS falls.

Optional Feature:
- VGA_CHECKSUM_EN defined: 16-bit accumulator adds {red,green,blue} (8b, zero-extended) for each pix_valid pixel, mod 2^16.
  - At each vs_fall, frame_sum <= accumulator and accumulator <= 0.
  - frame_sum updates only if the frame ended LOCKED.
- Undefined: accumulator absent; frame_sum tied to 16'h0000.

Test Plan:
- Nominal 800x525 timing, 4 frames: locked rises the cycle after the 3rd VS fall; frame_start pulses at the 4th; err_count = 0.
- Locked; drive RGB 8'hE5 at hcnt 144, vcnt 35 -> 2 clocks later pix_valid = 1, pix_x = 0, pix_y = 0, red = 7, green = 1, blue = 1. At hcnt 783 -> pix_x = 639; at hcnt 784 -> pix_valid = 0.
- Locked; shorten one line to 799 clocks -> locked falls next cycle, err_count = 1, pix_valid stays 0 until relock 2 good frames later.
- Frame of 524 lines -> frame_err, err_count +1, no lock. Assert reset mid-line -> all outputs 0 the next cycle.
- Hold HS low indefinitely -> hcnt saturates at 1023; 256+ bad lines -> err_count sticks at 255.
- With VGA_CHECKSUM_EN, constant RGB 8'h01 full frame -> frame_sum = 307200 mod 65536 = 16'hB000. Without the macro -> frame_sum = 0.
